// File: rtl/fifo_pkg.sv
// Shared definitions for the parametrised synchronous FIFO:
// default geometry, a clog2 helper for tools without $clog2, and the
// pointer-width computation (address bits plus one wrap bit).
package fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Pointer width: index bits plus the wrap bit.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// WIDTH x DEPTH simple dual-port storage for the FIFO.
// Synchronous write port, synchronous registered read port.
// The array itself carries no reset; only the read register does, so the
// FIFO output returns to zero on reset while the storage stays RAM-friendly.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Write port: store the word on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Next read data: fetch on an accepted read, otherwise hold.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  // Read register; cleared by reset so the FIFO output starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and a registered read-valid strobe.
// Optional sticky overflow/underflow flags with clear: define SYNC_FIFO_ERR_EN.
// Flags decode the registered count only, so they never glitch on we/re.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   re,
  output logic [WIDTH-1:0]       data_out,
  output logic                   data_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                   err_clr,
  output logic                   overflow,
  output logic                   underflow
`endif
);

  localparam int ADDR_W = clog2(DEPTH);
  localparam int PTR_W  = ptr_width(DEPTH);

  localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] count_q, count_d;
  logic             data_valid_q, data_valid_d;
  logic             wr_acc;
  logic             rd_acc;

  // Flags from the registered count; accepts qualified by pre-edge flags.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign wr_acc       = we && !full;
  assign rd_acc       = re && !empty;

  // Next pointers/count. The count is the pointer distance: pointers span
  // 2*DEPTH so the difference is exact in 0..DEPTH, and it naturally gives
  // +1 / -1 / unchanged for write-only / read-only / both-or-neither.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    data_valid_d = rd_acc;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ONE_C;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ONE_C;
    end
    count_d = wr_ptr_d - rd_ptr_d;
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_valid = data_valid_q;
  assign count      = count_q;

  // Storage; a write and a read never target the same live entry, so no
  // read-during-write resolution is needed.
  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr_acc),
    .waddr(wr_ptr_q[ADDR_W-1:0]),
    .wdata(data_in),
    .re   (rd_acc),
    .raddr(rd_ptr_q[ADDR_W-1:0]),
    .rdata(data_out)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags; a new event in the clearing cycle wins.
  always_comb begin
    overflow_d  = (overflow_q  && !err_clr) || (we && full);
    underflow_d = (underflow_q && !err_clr) || (re && empty);
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (default WIDTH=8, DEPTH=16).
// A reference queue models the FIFO; expected read data is pushed to a
// scoreboard when the read is driven and popped when data_valid appears.
module tb_sync_fifo_param;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       we = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       re = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
`ifdef SYNC_FIFO_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  int         mcount   = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_dout = 8'h00;
  logic       ov_m = 1'b0;
  logic       uf_m = 1'b0;

  sync_fifo_param dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (we),
    .data_in     (data_in),
    .re          (re),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .err_clr     (err_clr),
    .overflow    (overflow),
    .underflow   (underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check("count", int'(count), mcount);
    check("full", int'(full), int'(mcount == DEPTH));
    check("empty", int'(empty), int'(mcount == 0));
    check("almost_full", int'(almost_full), int'(mcount >= DEPTH - 2));
    check("almost_empty", int'(almost_empty), int'(mcount <= 2));
`ifdef SYNC_FIFO_ERR_EN
    check("overflow", int'(overflow), int'(ov_m));
    check("underflow", int'(underflow), int'(uf_m));
`endif
  endtask

  // One clock of stimulus: drive on the falling edge, check after the rising edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic clr);
    logic wacc;
    logic racc;
    @(negedge clk);
    we      = w;
    data_in = d;
    re      = r;
    err_clr = clr;
    wacc = w && (mcount != DEPTH);
    racc = r && (mcount != 0);
    ov_m = (ov_m && !clr) || (w && mcount == DEPTH);
    uf_m = (uf_m && !clr) || (r && mcount == 0);
    if (racc) exp_q.push_back(model_q.pop_front());
    if (wacc) model_q.push_back(d);
    mcount = mcount + int'(wacc) - int'(racc);
    @(posedge clk);
    #1;
    check("data_valid", int'(data_valid), int'(racc));
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_underrun", exp_q.size(), 1);
      end else begin
        last_dout = exp_q.pop_front();
        check("data_out", int'(data_out), int'(last_dout));
      end
    end else begin
      check("data_hold", int'(data_out), int'(last_dout));
    end
    check_state();
    $display("step we=%0d din=%02h re=%0d -> cnt=%0d dv=%0d dout=%02h",
             w, d, r, count, data_valid, data_out);
    we      = 1'b0;
    re      = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    mcount    = 0;
    last_dout = 8'h00;
    ov_m      = 1'b0;
    uf_m      = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_data_out", int'(data_out), 0);
    check("rst_data_valid", int'(data_valid), 0);
    check_state();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    // Power-on reset.
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs();
    $display("reset: cnt=%0d empty=%0d", count, empty);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fill to full with 0x01..0x10, then a refused 17th write.
    for (int i = 1; i <= 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    // Drain, then a refused 17th read (data_out holds 0x10).
    for (int i = 0; i < 17; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap-around traffic.
    for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous read/write at count 5.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
    // Fill to full, then simultaneous at full: only the read is taken.
    while (mcount < DEPTH) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    // Drain to empty, then simultaneous at empty: only the write is taken.
    while (mcount > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef SYNC_FIFO_ERR_EN
    // Error flags: overflow, underflow, clear, clear racing a new overflow.
    while (mcount < DEPTH) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hAB, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    while (mcount > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
`endif

    // Asynchronous reset mid-burst at count 7 with data_valid high.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_reset_outputs();
    $display("async reset: cnt=%0d dv=%0d dout=%02h", count, data_valid, data_out);
    @(negedge clk);
    rst_n = 1'b1;

    // Refill: first read returns the first post-reset word.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    v = 8'(exp_q.size());
    check("sb_leftover", int'(v), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
